// File: rtl/stream_downsize_pkg.sv
// Package stream_pkg: types and constants shared by the stream upsizer and
// downsizer.
//   stream_state_e    : two-state IDLE/SEND controller encoding
//   STREAM_MIN_RATIO  : smallest legal lane count per wide beat
//   STREAM_MIN_WIDTH  : smallest legal lane width
//   stream_idx_w()    : width of a lane index for a given lane count
package stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } stream_state_e;

  localparam int STREAM_MIN_RATIO = 2;
  localparam int STREAM_MIN_WIDTH = 1;

  // A lane index needs at least one bit, even for degenerate lane counts.
  function automatic int stream_idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/stream_downsize_lane_pick.sv
// lane_pick: combinational lane selector for the stream downsizer.
// Ports:
//   keep      in   per-lane valid mask
//   idx       in   currently selected lane
//   first_idx out  lowest lane with keep=1 (0 when keep is all zero)
//   next_idx  out  lowest lane with keep=1 strictly above idx
//   is_final  out  no lane with keep=1 lies above idx
module lane_pick
  import stream_pkg::*;
#(
  parameter int T_DATA_RATIO = 2,
  parameter int IDX_W        = stream_idx_w(T_DATA_RATIO)
) (
  input  logic [T_DATA_RATIO-1:0] keep,
  input  logic [IDX_W-1:0]        idx,
  output logic [IDX_W-1:0]        first_idx,
  output logic [IDX_W-1:0]        next_idx,
  output logic                    is_final
);

  // Kept lanes strictly above the current index.
  logic [T_DATA_RATIO-1:0] above;

  generate
    for (genvar gi = 0; gi < T_DATA_RATIO; gi++) begin : g_above
      assign above[gi] = keep[gi] && (32'(gi) > 32'(idx));
    end
  endgenerate

  // Scanning from the top down leaves the lowest matching lane in place.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
      if (keep[i]) begin
        first_idx = IDX_W'(i);
      end
      if (above[i]) begin
        next_idx = IDX_W'(i);
      end
    end
  end

  assign is_final = ~|above;

endmodule

// File: rtl/stream_downsize.sv
// stream_downsize: splits one wide beat of T_DATA_RATIO lanes into narrow
// T_DATA_WIDTH beats, lane 0 first, skipping lanes whose keep bit is 0.
// Optional feature macro: STREAM_DOWNSIZE_ERR_EN adds err_o.
// Ports:
//   clk_i      in   clock, all state on the rising edge
//   rst_n_i    in   asynchronous active-low reset
//   s_data_i   in   unpacked lane array, lane 0 sent first
//   s_keep_i   in   lane i valid when bit i is set
//   s_last_i   in   wide beat closes the packet
//   s_valid_i  in   wide beat offered
//   s_ready_o  out  wide beat accepted when s_valid_i && s_ready_o
//   m_data_o   out  narrow beat data
//   m_last_o   out  final narrow beat of the packet
//   m_valid_o  out  narrow beat offered
//   m_ready_i  in   narrow beat taken when m_valid_o && m_ready_i
//   err_o      out  (STREAM_DOWNSIZE_ERR_EN only) one-cycle pulse after a
//                   keep==0 beat is accepted
module stream_downsize
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
`ifdef STREAM_DOWNSIZE_ERR_EN
  ,
  output logic                    err_o
`endif
);

  localparam int IDX_W = stream_idx_w(T_DATA_RATIO);

  generate
    if (T_DATA_RATIO < STREAM_MIN_RATIO || T_DATA_WIDTH < STREAM_MIN_WIDTH) begin : g_bad_cfg
      $error("stream_downsize: T_DATA_RATIO must be >= 2 and T_DATA_WIDTH >= 1");
    end
  endgenerate

  stream_state_e           state_reg, state_next;
  logic [T_DATA_WIDTH-1:0] lane_reg [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] keep_reg;
  logic                    last_reg;
  logic [IDX_W-1:0]        idx_reg, idx_next;

  logic                    m_take;
  logic                    s_take;
  logic                    load;

  logic [IDX_W-1:0]        cur_first, cur_next, in_first, in_next;
  logic                    cur_final, in_final;

  // Lane walk over the buffered beat.
  lane_pick #(.T_DATA_RATIO(T_DATA_RATIO)) u_pick_cur (
    .keep      (keep_reg),
    .idx       (idx_reg),
    .first_idx (cur_first),
    .next_idx  (cur_next),
    .is_final  (cur_final)
  );

  // Starting lane of the beat being offered on the slave side.
  lane_pick #(.T_DATA_RATIO(T_DATA_RATIO)) u_pick_in (
    .keep      (s_keep_i),
    .idx       ('0),
    .first_idx (in_first),
    .next_idx  (in_next),
    .is_final  (in_final)
  );

  logic unused_pick;
  assign unused_pick = ^{cur_first, in_next, in_final};

  assign m_valid_o = (state_reg == SEND);
  assign m_data_o  = m_valid_o ? lane_reg[idx_reg] : '0;
  assign m_last_o  = m_valid_o && last_reg && cur_final;

  assign m_take    = m_valid_o && m_ready_i;
  // Taking the final lane frees the buffer in the same cycle, so the next
  // wide beat can be loaded without a bubble.
  assign s_ready_o = (state_reg == IDLE) || (m_take && cur_final);
  assign s_take    = s_valid_i && s_ready_o;
  // keep==0 beats are consumed but never enter the buffer.
  assign load      = s_take && (|s_keep_i);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          state_next = SEND;
          idx_next   = in_first;
        end
      end
      SEND: begin
        if (m_take) begin
          if (!cur_final) begin
            idx_next = cur_next;
          end else if (load) begin
            idx_next = in_first;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      keep_reg  <= '0;
      last_reg  <= 1'b0;
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        lane_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (load) begin
        keep_reg <= s_keep_i;
        last_reg <= s_last_i;
        for (int i = 0; i < T_DATA_RATIO; i++) begin
          lane_reg[i] <= s_data_i[i];
        end
      end
    end
  end

`ifdef STREAM_DOWNSIZE_ERR_EN
  logic err_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= s_take && !(|s_keep_i);
    end
  end

  assign err_o = err_reg;
`endif

endmodule
